uart_tx_arbiter: RTL and testbench

Shares the single `uart` transmitter between `NREQ` byte producers (CPU port, debug monitor, boot loader, etc.) using round-robin arbitration with per-frame locking. It owns the uart's `wr`/`adr`/`din` inputs and polls the uart status word, so requesters see only a valid/ready byte stream. A lock watchdog frees the transmitter from a requester that stalls mid-frame.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arbiter_rr_pick.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared uart register map constants and tx arbiter FSM states
package uart_pkg;

  typedef enum logic [1:0] {
    ST_ARB        = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_e;

  // adr 2'b10 selects both the tx data write and the status word on dout
  localparam logic [1:0] UART_ADR_TXSTAT  = 2'b10;
  localparam int         UART_TX_BUSY_BIT = 1;
  localparam int         UART_RDY_BIT     = 0;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin selector
//
// Purpose: pick the first set bit of mask strictly after ptr, wrapping mod N.
// Ports:
//   mask   in  N  candidate requests
//   ptr    in  W  last winner; search starts at ptr+1
//   onehot out N  winner as one-hot (zero when none)
//   idx    out W  winner index (zero when none)
//   any    out 1  mask had at least one bit set
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    logic [W-1:0] j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = '0;
    // k runs 1..N so ptr itself is visited last
    for (int k = 1; k <= N; k++) begin
      j = W'((int'(ptr) + k) % N);
      if (!any && mask[j]) begin
        any       = 1'b1;
        idx       = j;
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, frame-locking arbiter in front of one uart tx
//
// Purpose: share one uart transmitter between NREQ byte producers.
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   req_valid     in  NREQ    requester has a byte
//   req_data      in  8*NREQ  byte i at [8*i +: 8]
//   req_last      in  NREQ    byte ends its frame (0 keeps the grant locked)
//   req_ready     out NREQ    one-hot accept strobe, only in ARB
//   uart_wr       out 1       one-cycle write strobe to the uart
//   uart_adr      out 2       constant tx/status address
//   uart_din      out 8       byte to transmit, held between grants
//   uart_dout     in  8       uart status; bit 1 = tx busy
//   grant_id      out IW      requester of the last accepted byte
//   locked        out 1       a multi-byte frame is in progress
//   busy          out 1       FSM is not in ARB
//   timeout_err   out 1       pulse when a stalled owner loses its lock
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    uart_wr,
  output logic [1:0]              uart_adr,
  output logic [7:0]              uart_din,
  input  logic [7:0]              uart_dout,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    locked,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int IW = $clog2(NREQ);

  arb_state_e       state_q, state_d;
  logic [7:0]       din_q;
  logic [IW-1:0]    grant_q;
  logic [IW-1:0]    rr_ptr_q;
  logic             locked_q;
  logic [15:0]      wd_q;

  logic             tx_busy;
  logic [NREQ-1:0]  owner_oh;
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             grant;
  logic             owner_valid;
  logic             wd_run;
  logic             wd_hit;
  logic             unused_dout;

  assign tx_busy     = uart_dout[UART_TX_BUSY_BIT];
  assign unused_dout = ^{uart_dout[7:2], uart_dout[0]};

  // rr_ptr always equals the last winner, so it doubles as the lock owner
  always_comb begin
    owner_oh           = '0;
    owner_oh[rr_ptr_q] = 1'b1;
  end

  assign eligible = locked_q ? (req_valid & owner_oh) : req_valid;

  rr_pick #(.N(NREQ), .W(IW)) u_pick (
    .mask   (eligible),
    .ptr    (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // the busy gate also covers a reset taken while the uart was still shifting
  assign grant     = (state_q == ST_ARB) && pick_any && !tx_busy;
  assign req_ready = grant ? pick_oh : '0;

  // owner valid in the same cycle suppresses the timeout, so grant and wd_hit never coincide
  assign owner_valid = |(req_valid & owner_oh);
  assign wd_run      = (state_q == ST_ARB) && locked_q && !owner_valid;
  assign wd_hit      = wd_run && (wd_q == 16'(LOCK_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:        if (grant) state_d = ST_ISSUE;
      ST_ISSUE:      state_d = ST_WAIT_START;
      ST_WAIT_START: state_d = ST_WAIT_DONE;   // uart raises busy during this cycle
      ST_WAIT_DONE:  if (!tx_busy) state_d = ST_ARB;
      default:       state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_ARB;
      din_q    <= 8'h00;
      grant_q  <= '0;
      rr_ptr_q <= IW'(NREQ - 1);
      locked_q <= 1'b0;
      wd_q     <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (grant) begin
        din_q    <= req_data[8*int'(pick_idx) +: 8];
        grant_q  <= pick_idx;
        rr_ptr_q <= pick_idx;
        locked_q <= !req_last[pick_idx];
      end else if (wd_hit) begin
        // rr_ptr stays on the old owner so the next grant goes elsewhere first
        locked_q <= 1'b0;
      end
      wd_q <= (wd_run && !wd_hit) ? wd_q + 16'd1 : 16'h0000;
    end
  end

  assign uart_wr     = (state_q == ST_ISSUE);
  assign uart_adr    = UART_ADR_TXSTAT;
  assign uart_din    = din_q;
  assign grant_id    = grant_q;
  assign locked      = locked_q;
  assign busy        = (state_q != ST_ARB);
  assign timeout_err = wd_hit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural uart
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int CPB = 4;   // uart cycles per bit; a frame is 10 bits

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        uart_wr;
  logic [1:0]  uart_adr;
  logic [7:0]  uart_din;
  logic [7:0]  uart_dout;
  logic [1:0]  grant_id;
  logic        locked, busy, timeout_err;

  logic ub = 1'b0;          // behavioural uart tx busy
  logic force_busy = 1'b0;
  int   ucnt = 0;
  assign uart_dout = {6'b0, ub | force_busy, 1'b0};

  int checks = 0;
  int errors = 0;

  logic [8:0] src_q [4][$];   // {last, data} per requester
  logic [9:0] exp_q [$];      // {id, data} expected at the uart
  int         glog  [$];      // order of uart writes by requester
  int         gap   [4];
  bit         rand_on = 1'b0;
  int         mdl_ptr = 3;
  bit         mdl_locked = 1'b0;
  bit         chk_lock = 1'b0;
  int         to_pulses = 0;

  uart_tx_arbiter #(.NREQ(N), .LOCK_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .uart_wr     (uart_wr),
    .uart_adr    (uart_adr),
    .uart_din    (uart_din),
    .uart_dout   (uart_dout),
    .grant_id    (grant_id),
    .locked      (locked),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // uart is not tied to the arbiter reset: it keeps shifting across one
  always @(posedge clk) begin
    if (uart_wr && uart_adr == 2'b10 && !ub) begin
      ub   <= 1'b1;
      ucnt <= 10*CPB - 1;
    end else if (ub) begin
      if (ucnt == 0) ub <= 1'b0;
      else ucnt <= ucnt - 1;
    end
  end

  // requester drivers
  initial begin
    logic [3:0] hs;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          void'(src_q[i].pop_front());
          gap[i] = rand_on ? $urandom_range(0, 3) : 0;
        end else if (rand_on && req_valid[i] && $urandom_range(0, 15) == 0) begin
          gap[i] = $urandom_range(1, 3);
        end
        if (gap[i] > 0) begin
          gap[i]--;
          req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = (src_q[i].size() != 0);
        end
        if (src_q[i].size() != 0) begin
          req_data[8*i +: 8] = src_q[i][0][7:0];
          req_last[i]        = src_q[i][0][8];
        end
      end
    end
  end

  function automatic int mdl_pick(input logic [3:0] v);
    if (mdl_locked) return mdl_ptr;
    for (int k = 1; k <= N; k++) begin
      if (v[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
    end
    return -1;
  endfunction

  // handshake monitor: arbitration model and expected-byte producer
  always @(negedge clk) begin
    int e;
    int w;
    if (!rst) begin
      mdl_ptr    = 3;
      mdl_locked = 1'b0;
      chk_lock   = 1'b0;
    end else begin
      if (chk_lock) begin
        chk("locked_after_accept", {31'b0, locked}, {31'b0, mdl_locked});
        chk_lock = 1'b0;
      end
      if (uart_dout[1]) chk("ready_while_uart_busy", {28'b0, req_ready}, 32'h0);
      if (req_ready != 4'b0) begin
        chk("ready_onehot_and_valid",
            {31'b0, ($onehot(req_ready) && ((req_ready & ~req_valid) == 4'b0))}, 32'h1);
        w = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) w = i;
        e = mdl_pick(req_valid);
        chk("winner", w, e);
        if (e >= 0 && src_q[e].size() != 0) begin
          exp_q.push_back({2'(e), src_q[e][0][7:0]});
          mdl_ptr    = e;
          mdl_locked = !src_q[e][0][8];
          chk_lock   = 1'b1;
        end
      end
    end
  end

  // uart-side monitor
  always @(negedge clk) begin
    logic [9:0] e;
    if (timeout_err) to_pulses++;
    if (uart_wr) begin
      chk("wr_while_uart_busy", {31'b0, ub}, 32'h0);
      chk("uart_adr", {30'b0, uart_adr}, 32'h2);
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_din", {24'b0, uart_din}, {24'b0, e[7:0]});
        chk("wr_grant_id", {30'b0, grant_id}, {30'b0, e[9:8]});
        glog.push_back(int'(e[9:8]));
      end
    end
  end

  function automatic bit all_idle();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return exp_q.size() == 0 && !ub && !busy;
  endfunction

  task automatic drain(input string name);
    int t;
    t = 0;
    while (t < 5000 && !all_idle()) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_drain"}, {31'b0, t < 5000}, 32'h1);
  endtask

  task automatic chk_log(input string name, input int a0, input int a1, input int a2,
                         input int a3, input int a4);
    int ex[5];
    ex = '{a0, a1, a2, a3, a4};
    chk({name, "_count"}, glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk({name, "_order"}, glog[i], ex[i]);
    glog.delete();
  endtask

  initial begin
    int t;
    int tp;
    int len;
    for (int i = 0; i < N; i++) gap[i] = 0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_uart_wr", {31'b0, uart_wr}, 32'h0);
    chk("rst_uart_adr", {30'b0, uart_adr}, 32'h2);
    chk("rst_uart_din", {24'b0, uart_din}, 32'h0);
    chk("rst_grant_id", {30'b0, grant_id}, 32'h0);
    chk("rst_locked", {31'b0, locked}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_timeout", {31'b0, timeout_err}, 32'h0);
    chk("rst_ready", {28'b0, req_ready}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // round robin from reset: pointer starts at NREQ-1
    for (int i = 0; i < N; i++) src_q[i].push_back({1'b1, 8'(8'hA0 + i)});
    src_q[0].push_back({1'b1, 8'hA4});
    drain("rr");
    chk_log("rr", 0, 1, 2, 3, 0);

    // single byte
    src_q[0].push_back({1'b1, 8'h55});
    t = 0;
    do begin @(negedge clk); t++; end while (req_ready == 4'b0 && t < 200);
    chk("single_ready", {28'b0, req_ready}, 32'h1);
    @(negedge clk);
    chk("single_wr", {31'b0, uart_wr}, 32'h1);
    chk("single_din", {24'b0, uart_din}, 32'h55);
    chk("single_ready_drop", {28'b0, req_ready}, 32'h0);
    drain("single");
    chk("single_locked", {31'b0, locked}, 32'h0);
    chk("single_busy", {31'b0, busy}, 32'h0);
    glog.delete();

    // frame lock: req2 owns the uart for three bytes
    src_q[2].push_back({1'b0, 8'h21});
    src_q[2].push_back({1'b0, 8'h22});
    src_q[2].push_back({1'b1, 8'h23});
    t = 0;
    while (src_q[2].size() == 3 && t < 200) begin @(negedge clk); t++; end
    src_q[0].push_back({1'b1, 8'h01});
    src_q[1].push_back({1'b1, 8'h11});
    drain("lock");
    chk_log("lock", 2, 2, 2, 0, 1);

    // lock watchdog: req1 stalls mid-frame, req3 waits
    tp = to_pulses;
    src_q[1].push_back({1'b0, 8'h5A});
    t = 0;
    while (src_q[1].size() != 0 && t < 200) begin @(negedge clk); t++; end
    src_q[3].push_back({1'b1, 8'h77});
    t = 0;
    do begin @(negedge clk); t++; end while (!ub && t < 200);
    do begin @(negedge clk); t++; end while (ub && t < 400);
    chk("to_uart_idle_seen", {31'b0, t < 400}, 32'h1);
    for (int n = 0; n <= 17; n++) begin
      if (n > 0) @(negedge clk);
      chk("to_pulse_timing", {31'b0, timeout_err}, {31'b0, n == 16});
      if (n == 16) mdl_locked = 1'b0;
      if (n == 17) begin
        chk("to_locked_cleared", {31'b0, locked}, 32'h0);
        chk("to_next_grant", {28'b0, req_ready}, 32'h8);
      end
    end
    drain("to");
    chk("to_pulse_count", to_pulses - tp, 1);
    glog.delete();

    // reset in the middle of a byte
    tp = to_pulses;
    src_q[0].push_back({1'b1, 8'hC3});
    t = 0;
    do begin @(negedge clk); t++; end while (!ub && t < 200);
    repeat (4*CPB + 1) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    src_q[0].push_back({1'b1, 8'h3C});
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstmid_uart_still_busy", {31'b0, ub}, 32'h1);
    drain("rstmid");
    chk("rstmid_no_timeout", to_pulses - tp, 0);
    chk("rstmid_last_id", glog.size() > 0 ? glog[glog.size()-1] : -1, 0);
    glog.delete();

    // busy gate held by status bit
    force_busy = 1'b1;
    src_q[2].push_back({1'b1, 8'hB7});
    repeat (12) begin
      @(negedge clk);
      chk("gate_ready", {28'b0, req_ready}, 32'h0);
    end
    @(posedge clk); #1 force_busy = 1'b0;
    drain("gate");
    glog.delete();

    // randomized frames with valid gaps
    rand_on = 1'b1;
    tp = to_pulses;
    for (int i = 0; i < N; i++) begin
      for (int f = 0; f < 4; f++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) src_q[i].push_back({b == len - 1, 8'($urandom)});
      end
    end
    drain("rand");
    chk("rand_no_timeout", to_pulses - tp, 0);
    chk("rand_exp_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL global_time_limit actual=expired required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
